// File: rtl/regbank_wb_arbiter.sv
// Write-port owner for the register bank: zeroes registers 1..2**SIZE-1 after reset,
// then round-robin arbitrates two writeback requesters onto the registered we3/A3/WD3 port.
module regbank_wb_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [SIZE-1:0]       a_addr,
  input  logic [WIDTH-1:0]      a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [SIZE-1:0]       b_addr,
  input  logic [WIDTH-1:0]      b_data,
  output logic                  b_ready,
  output logic                  we3,
  output logic [SIZE-1:0]       A3,
  output logic [WIDTH-1:0]      WD3,
  output logic                  init_done,
  output logic [(2**SIZE)-1:0]  pending
);

  localparam int unsigned     NREG      = 2**SIZE;
  localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(NREG - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic {GNT_A, GNT_B} grant_t;

  state_t            r_state,     w_state_nxt;
  logic [SIZE-1:0]   r_init_ptr,  w_init_ptr_nxt;
  grant_t            r_last,      w_last_nxt;
  logic              r_we3,       w_we3_nxt;
  logic [SIZE-1:0]   r_a3,        w_a3_nxt;
  logic [WIDTH-1:0]  r_wd3,       w_wd3_nxt;
  logic              r_init_done, w_init_done_nxt;
  logic [NREG-1:0]   r_pending,   w_pending_nxt;

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic [SIZE-1:0]   w_addr;
  logic [WIDTH-1:0]  w_data;

  // State and write-port registers; last_grant resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_init_ptr  <= SIZE'(1);
      r_last      <= GNT_B;
      r_we3       <= 1'b0;
      r_a3        <= '0;
      r_wd3       <= '0;
      r_init_done <= 1'b0;
      r_pending   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_ptr  <= w_init_ptr_nxt;
      r_last      <= w_last_nxt;
      r_we3       <= w_we3_nxt;
      r_a3        <= w_a3_nxt;
      r_wd3       <= w_wd3_nxt;
      r_init_done <= w_init_done_nxt;
      r_pending   <= w_pending_nxt;
    end
  end

  // Init sweep, arbitration and commit; grants open only once init_done is visible.
  always_comb begin
    w_state_nxt     = r_state;
    w_init_ptr_nxt  = r_init_ptr;
    w_last_nxt      = r_last;
    w_we3_nxt       = 1'b0;
    w_a3_nxt        = r_a3;
    w_wd3_nxt       = r_wd3;
    w_init_done_nxt = r_init_done;
    w_pending_nxt   = '0;
    w_gnt_a         = 1'b0;
    w_gnt_b         = 1'b0;
    w_addr          = a_addr;
    w_data          = a_data;

    unique case (r_state)
      S_INIT: begin
        w_we3_nxt      = 1'b1;
        w_a3_nxt       = r_init_ptr;
        w_wd3_nxt      = '0;
        w_init_ptr_nxt = r_init_ptr + SIZE'(1);
        if (r_init_ptr == LAST_ADDR) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_init_done_nxt = 1'b1;
        if (r_init_done) begin
          if (a_valid && b_valid) begin
            w_gnt_a = (r_last == GNT_B);
            w_gnt_b = (r_last == GNT_A);
          end else begin
            w_gnt_a = a_valid;
            w_gnt_b = b_valid;
          end
        end
        if (w_gnt_b) begin
          w_addr = b_addr;
          w_data = b_data;
        end
        // x0 writes are accepted but never reach the bank.
        if (w_gnt_a || w_gnt_b) begin
          w_last_nxt = w_gnt_a ? GNT_A : GNT_B;
          w_a3_nxt   = w_addr;
          w_wd3_nxt  = w_data;
          w_we3_nxt  = (w_addr != '0);
          if (w_addr != '0) begin
            w_pending_nxt = NREG'(1) << w_addr;
          end
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign a_ready   = w_gnt_a;
  assign b_ready   = w_gnt_b;
  assign we3       = r_we3;
  assign A3        = r_a3;
  assign WD3       = r_wd3;
  assign init_done = r_init_done;
  assign pending   = r_pending;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench for regbank_wb_arbiter: random and directed requester traffic,
// expected commits queued by a round-robin reference model and checked by a monitor.
module tb_regbank_wb_arbiter;

  localparam int BIG = 32'h7fff_ffff;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
  } req_t;

  typedef struct {
    int         stamp;
    logic       we;
    logic [2:0] addr;
    logic [3:0] data;
    logic [7:0] pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [2:0] a_addr = '0;
  logic [3:0] a_data = '0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [2:0] b_addr = '0;
  logic [3:0] b_data = '0;
  logic       b_ready;
  logic       we3;
  logic [2:0] A3;
  logic [3:0] WD3;
  logic       init_done;
  logic [7:0] pending;

  int   nvec = 0;
  int   nerr = 0;
  int   edge_cnt = 0;
  int   init_done_edge = BIG;
  bit   mon_en = 0;
  bit   gaps = 0;
  bit   last_b = 1;
  bit   a_acc = 0;
  bit   b_acc = 0;
  req_t aq[$];
  req_t bq[$];
  exp_t expq[$];

  regbank_wb_arbiter #(.WIDTH(4), .SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we3(we3), .A3(A3), .WD3(WD3), .init_done(init_done), .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic exp_t grant_entry(input int stamp, input logic [2:0] addr, input logic [3:0] data);
    exp_t e;
    e.stamp = stamp;
    e.we    = (addr != 3'd0);
    e.addr  = addr;
    e.data  = data;
    e.pend  = (addr != 3'd0) ? (8'd1 << addr) : 8'd0;
    return e;
  endfunction

  // Requester driver plus round-robin reference model for the ready outputs.
  always begin
    bit open, ga, gb;
    @(negedge clk);
    if (a_acc) begin a_valid = 1'b0; a_acc = 0; end
    if (b_acc) begin b_valid = 1'b0; b_acc = 0; end
    if (rst_n) begin
      if (!a_valid && aq.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        a_valid = 1'b1; a_addr = aq[0].addr; a_data = aq[0].data;
      end
      if (!b_valid && bq.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        b_valid = 1'b1; b_addr = bq[0].addr; b_data = bq[0].data;
      end
    end
    #1;
    open = rst_n && (edge_cnt >= init_done_edge);
    ga = 0; gb = 0;
    if (open) begin
      if (a_valid && b_valid) begin ga = last_b; gb = !last_b; end
      else begin ga = a_valid; gb = b_valid; end
    end
    nvec++;
    if (a_ready !== ga || b_ready !== gb) begin
      nerr++;
      $display("FAIL ready t=%0t: a_ready=%b b_ready=%b (a_valid=%b b_valid=%b), want %b %b",
               $time, a_ready, b_ready, a_valid, b_valid, ga, gb);
    end
    if (ga) begin
      expq.push_back(grant_entry(edge_cnt + 1, a_addr, a_data));
      void'(aq.pop_front()); a_acc = 1; last_b = 0;
    end
    if (gb) begin
      expq.push_back(grant_entry(edge_cnt + 1, b_addr, b_data));
      void'(bq.pop_front()); b_acc = 1; last_b = 1;
    end
  end

  // Monitor: pops the commit due on this edge, otherwise expects an idle port.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && mon_en) begin
      while (expq.size() > 0 && expq[0].stamp < edge_cnt) begin
        e = expq.pop_front();
        nvec++; nerr++;
        $display("FAIL commit_missed: edge %0d passed with entry A3=%0d WD3=%0d still queued, want it committed",
                 edge_cnt, e.addr, e.data);
      end
      nvec++;
      if (expq.size() > 0 && expq[0].stamp == edge_cnt) begin
        e = expq.pop_front();
        if (we3 !== e.we || A3 !== e.addr || WD3 !== e.data || pending !== e.pend) begin
          nerr++;
          $display("FAIL commit edge %0d: we3=%b A3=%0d WD3=%0d pending=%b, want we3=%b A3=%0d WD3=%0d pending=%b",
                   edge_cnt, we3, A3, WD3, pending, e.we, e.addr, e.data, e.pend);
        end
      end else if (we3 !== 1'b0 || pending !== 8'd0) begin
        nerr++;
        $display("FAIL idle edge %0d: we3=%b A3=%0d pending=%b, want we3=0 pending=00000000",
                 edge_cnt, we3, A3, pending);
      end
      nvec++;
      if (init_done !== (edge_cnt >= init_done_edge)) begin
        nerr++;
        $display("FAIL init_done edge %0d: got %b, want %b", edge_cnt, init_done, edge_cnt >= init_done_edge);
      end
    end
  end

  task automatic do_reset();
    int base;
    rst_n = 1'b0; mon_en = 0; init_done_edge = BIG;
    #1;
    nvec++;
    if (we3 !== 1'b0 || A3 !== 3'd0 || WD3 !== 4'd0 || init_done !== 1'b0 || pending !== 8'd0 ||
        a_ready !== 1'b0 || b_ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: we3=%b A3=%0d WD3=%0d init_done=%b pending=%b a_ready=%b b_ready=%b, want all zero",
               we3, A3, WD3, init_done, pending, a_ready, b_ready);
    end
    expq.delete(); last_b = 1;
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    base = edge_cnt + 1;
    for (int i = 1; i < 8; i++) begin
      exp_t e;
      e.stamp = base + i - 1; e.we = 1'b1; e.addr = 3'(i); e.data = 4'd0; e.pend = 8'd0;
      expq.push_back(e);
    end
    init_done_edge = base + 7;
    mon_en = 1;
  endtask

  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while ((aq.size() != 0 || bq.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (aq.size() != 0 || bq.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL handshake_timeout: %0d A and %0d B requests still waiting after %0d cycles, want 0",
               aq.size(), bq.size(), bound);
      aq.delete(); bq.delete();
      a_valid = 1'b0; b_valid = 1'b0;
    end
  endtask

  task automatic push_a(input logic [2:0] addr, input logic [3:0] data);
    req_t r; r.addr = addr; r.data = data; aq.push_back(r);
  endtask

  task automatic push_b(input logic [2:0] addr, input logic [3:0] data);
    req_t r; r.addr = addr; r.data = data; bq.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Both requesters held valid through init, then contending: A,B,A,B...
    gaps = 0;
    for (int i = 0; i < 6; i++) begin push_a(3'd2, 4'd3); push_b(3'd4, 4'd6); end
    wait_empty(100);
    repeat (3) @(posedge clk);
    push_a(3'd5, 4'd9);
    wait_empty(50);
    repeat (3) @(posedge clk);
    push_b(3'd0, 4'd15);
    wait_empty(50);
    push_a(3'd3, 4'd7);
    wait_empty(50);
    repeat (2) @(posedge clk);
    push_a(3'd6, 4'd1);
    push_a(3'd6, 4'd2);
    wait_empty(50);
    repeat (3) @(posedge clk);
    // Randomized traffic with idle gaps and occasional x0 targets.
    gaps = 1;
    for (int i = 0; i < 60; i++) begin
      push_a(3'($urandom_range(7)), 4'($urandom_range(15)));
      push_b(3'($urandom_range(7)), 4'($urandom_range(15)));
    end
    wait_empty(2000);
    gaps = 0;
    repeat (3) @(posedge clk);
    // Reset pulsed between edges right after an accepted transfer.
    push_a(3'd5, 4'd9);
    wait_empty(50);
    #2;
    do_reset();
    push_b(3'd1, 4'd10);
    push_a(3'd7, 4'd4);
    wait_empty(100);
    repeat (5) @(negedge clk);
    nvec++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expected commits never seen, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
